// File: rtl/v5_trap_shaper_pkg.sv
`default_nettype none
// ============================================================================
// Module   : v5_parameters (package)
// Brief    : Shared defaults, configuration record and FSM states for the
//            v5 trapezoidal shaper.
// Revision : 1.0
// ============================================================================
package v5_parameters;

    localparam int ADC_W_DEF     = 14;
    localparam int OUT_W_DEF     = 32;
    localparam int M_W_DEF       = 16;
    localparam int MAX_DEPTH_DEF = 64;
    localparam int DW_DEF        = $clog2(MAX_DEPTH_DEF + 1);

    typedef struct packed {
        logic [DW_DEF-1:0]  k;
        logic [DW_DEF-1:0]  l;
        logic [M_W_DEF-1:0] m;
    } trap_cfg_t;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        RUN  = 1'b1
    } trap_state_t;

    function automatic logic cfg_is_legal(input int k, input int l, input int max_depth);
        return (k >= 1) && (l >= k) && ((k + l) <= max_depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/v5_trap_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : v5_trap_delay_line
// Brief    : Circular sample buffer, one write port and three offset read
//            ports; taps older than the fill count read as zero.
// Revision : 1.0
// ============================================================================
module v5_trap_delay_line
    import v5_parameters::*;
#(
    parameter int DATA_W = ADC_W_DEF,
    parameter int DEPTH  = MAX_DEPTH_DEF,
    parameter int DW     = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clear,
    input  logic                   i_wr_en,
    input  logic [DATA_W-1:0]      i_wr_data,
    input  logic [2:0][DW-1:0]     i_off,
    output logic [2:0][DATA_W-1:0] o_tap,
    output logic [DW-1:0]          o_fill_cnt
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DW:0] c_DEPTH = (DW+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [DW-1:0]     r_fill_cnt;

    // Buffer contents are never reset; masking hides stale entries.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_fill_cnt <= '0;
        end else begin
            if (i_wr_en) begin
                r_wptr <= (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + AW'(1);
            end
            if (i_clear) begin
                r_fill_cnt <= '0;
            end else if (i_wr_en && (r_fill_cnt < DW'(DEPTH))) begin
                r_fill_cnt <= r_fill_cnt + DW'(1);
            end
        end
    end

    // Reads see the pre-write contents, so offset DEPTH returns the oldest sample.
    for (genvar gi = 0; gi < 3; gi++) begin : g_tap
        logic [DW:0]   w_sum;
        logic [AW-1:0] w_addr;
        assign w_sum    = (DW+1)'(r_wptr) + c_DEPTH - (DW+1)'(i_off[gi]);
        assign w_addr   = AW'((w_sum >= c_DEPTH) ? (w_sum - c_DEPTH) : w_sum);
        assign o_tap[gi] = (r_fill_cnt < i_off[gi]) ? '0 : r_mem[w_addr];
    end

    assign o_fill_cnt = r_fill_cnt;

endmodule
`default_nettype wire

// File: rtl/v5_trap_shaper.sv
`default_nettype none
// ============================================================================
// Module   : v5_trap_shaper
// Brief    : 3-stage streaming trapezoidal shaper with run-time k/l/M.
//            Define TRAP_SATURATE_EN for saturating arithmetic and sticky ovf.
// Revision : 1.0
// ============================================================================
module v5_trap_shaper
    import v5_parameters::*;
#(
    parameter int ADC_W     = ADC_W_DEF,
    parameter int OUT_W     = OUT_W_DEF,
    parameter int M_W       = M_W_DEF,
    parameter int MAX_DEPTH = MAX_DEPTH_DEF,
    parameter int K_DEF     = 8,
    parameter int L_DEF     = 16,
    parameter int M_DEF     = 100,
    localparam int DW       = $clog2(MAX_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [ADC_W-1:0] in_data,
    input  logic             cfg_load,
    input  logic [DW-1:0]    cfg_k,
    input  logic [DW-1:0]    cfg_l,
    input  logic [M_W-1:0]   cfg_m,
    output logic             cfg_err,
    output logic             filling,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             ovf
);

`ifdef TRAP_SATURATE_EN
    localparam int MDW = OUT_W + M_W + 1;
`else
    localparam int MDW = OUT_W;
`endif

    logic [DW-1:0]            r_k, r_l;
    logic [M_W-1:0]           r_m;
    trap_state_t              r_state, w_state_next;
    logic                     r_cfg_err;
    logic                     r_v1, r_v2, r_v3;
    logic signed [OUT_W-1:0]  r_d1, r_p, r_s;
    logic signed [MDW-1:0]    r_md2;

    logic                     w_cfg_ok, w_cfg_apply, w_cfg_rej, w_accept;
    logic [DW-1:0]            w_kl, w_fill_cnt;
    logic [2:0][DW-1:0]       w_off;
    logic [2:0][ADC_W-1:0]    w_tap;
    logic signed [ADC_W+1:0]  w_d;
    logic signed [MDW-1:0]    w_md;
    logic signed [OUT_W-1:0]  w_p_next, w_r, w_s_next;

    assign w_cfg_ok    = cfg_is_legal(int'(cfg_k), int'(cfg_l), MAX_DEPTH);
    assign w_cfg_apply = cfg_load & w_cfg_ok;
    assign w_cfg_rej   = cfg_load & ~w_cfg_ok;
    assign w_accept    = in_valid & ~cfg_load;

    assign w_kl  = r_k + r_l;
    assign w_off = {w_kl, r_l, r_k};

    v5_trap_delay_line #(
        .DATA_W (ADC_W),
        .DEPTH  (MAX_DEPTH)
    ) u_delay (
        .clk        (clk),
        .rst        (reset),
        .i_clear    (w_cfg_apply),
        .i_wr_en    (w_accept),
        .i_wr_data  (in_data),
        .i_off      (w_off),
        .o_tap      (w_tap),
        .o_fill_cnt (w_fill_cnt)
    );

    // Two guard bits hold the four-term sum exactly.
    assign w_d = (ADC_W+2)'($signed(in_data))  - (ADC_W+2)'($signed(w_tap[0]))
               - (ADC_W+2)'($signed(w_tap[1])) + (ADC_W+2)'($signed(w_tap[2]));
    assign w_md = MDW'($signed({1'b0, r_m})) * MDW'(r_d1);

`ifdef TRAP_SATURATE_EN
    localparam logic signed [OUT_W-1:0] c_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] c_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic signed [OUT_W:0] w_p_sum, w_s_sum;
    logic signed [MDW:0]   w_r_sum;
    logic                  w_sat_p, w_sat_r, w_sat_s;
    logic                  r_ovf;

    assign w_p_sum  = (OUT_W+1)'(r_p) + (OUT_W+1)'(r_d1);
    assign w_sat_p  = w_p_sum[OUT_W] != w_p_sum[OUT_W-1];
    assign w_p_next = w_sat_p ? (w_p_sum[OUT_W] ? c_MIN : c_MAX) : w_p_sum[OUT_W-1:0];

    assign w_r_sum  = (MDW+1)'(r_p) + (MDW+1)'(r_md2);
    assign w_sat_r  = (w_r_sum > (MDW+1)'(c_MAX)) || (w_r_sum < (MDW+1)'(c_MIN));
    assign w_r      = w_sat_r ? (w_r_sum[MDW] ? c_MIN : c_MAX) : w_r_sum[OUT_W-1:0];

    assign w_s_sum  = (OUT_W+1)'(r_s) + (OUT_W+1)'(w_r);
    assign w_sat_s  = w_s_sum[OUT_W] != w_s_sum[OUT_W-1];
    assign w_s_next = w_sat_s ? (w_s_sum[OUT_W] ? c_MIN : c_MAX) : w_s_sum[OUT_W-1:0];

    always_ff @(posedge clk) begin
        if (reset || w_cfg_apply) begin
            r_ovf <= 1'b0;
        end else if ((r_v1 && w_sat_p) || (r_v2 && (w_sat_r || w_sat_s))) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`else
    assign w_p_next = r_p + r_d1;
    assign w_r      = r_p + r_md2;
    assign w_s_next = r_s + w_r;
    assign ovf      = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        filling      = (r_state == FILL);
        if (w_cfg_apply) begin
            w_state_next = FILL;
        end else if (({1'b0, w_fill_cnt} + (DW+1)'(w_accept)) >= {1'b0, w_kl}) begin
            w_state_next = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_k       <= DW'(K_DEF);
            r_l       <= DW'(L_DEF);
            r_m       <= M_W'(M_DEF);
            r_state   <= FILL;
            r_cfg_err <= 1'b0;
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_v3      <= 1'b0;
            r_d1      <= '0;
            r_md2     <= '0;
            r_p       <= '0;
            r_s       <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cfg_err <= w_cfg_rej;
            if (w_cfg_apply) begin
                // New config restarts the filter; in-flight samples are dropped.
                r_k  <= cfg_k;
                r_l  <= cfg_l;
                r_m  <= cfg_m;
                r_v1 <= 1'b0;
                r_v2 <= 1'b0;
                r_v3 <= 1'b0;
                r_p  <= '0;
                r_s  <= '0;
            end else begin
                r_v1 <= w_accept;
                if (w_accept) begin
                    r_d1 <= OUT_W'(w_d);
                end
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_p   <= w_p_next;
                    r_md2 <= w_md;
                end
                r_v3 <= r_v2;
                if (r_v2) begin
                    r_s <= w_s_next;
                end
            end
        end
    end

    assign cfg_err   = r_cfg_err;
    assign out_valid = r_v3;
    assign out_data  = r_s;

endmodule
`default_nettype wire
